// File: rtl/baud_pkg.sv
// Shared constants and divisor record for the baud tick generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package baud_pkg;

  // Smallest integer divisor the period counter can honour.
  localparam int DIV_MIN    = 2;

  // Default build geometry.
  localparam int CNT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OSR_DEF    = 16;
  localparam int DIV_RST_DEF = 27;

  // Divisor as held in the active and shadow registers.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]  ipart;  // whole clocks per oversample tick
    logic [FRAC_W_DEF-1:0] fpart;  // sixteenths (2^FRAC_W) of a clock
  } baud_div_t;

endpackage

// File: rtl/baud_tick_gen_frac_accum.sv
// Fractional phase accumulator: adds the divisor fraction once per tick, flags overflow.
// Latency: carry is registered, valid the cycle after the stepping tick.
// Backpressure: none; step and clr are single-cycle qualifiers.
//
// Ports: in_clk/rst clock and async active-low reset; step advances the
// accumulator; clr zeroes accumulator and carry; frac is the addend; carry
// tells the period counter to stretch the next period by one clock.
module frac_accum #(
  parameter int FRAC_W = baud_pkg::FRAC_W_DEF
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clr,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      // Carry is held until the next tick so it selects a whole period.
      {carry, acc} <= sum;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: single-cycle oversample, mid-bit and bit-boundary enables.
// Latency: strobes are registered, one cycle after the counter reaches P-1.
// Backpressure: none; en=0 freezes all state, load is shadowed while running.
//
// Ports: in_clk, rst (async active-low); en run enable; div_int/div_frac new
// divisor; load takes the divisor; restart realigns phase to zero; os_tick,
// mid_tick, bit_tick strobes; cfg_err flags an active integer divisor < 2.
// Optional macro BAUD_FRAC_EN adds the fractional accumulator; without it
// div_frac is ignored and the period is always div_int.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int OSR     = OSR_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  input  logic              restart,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int OS_W = $clog2(OSR);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OSR / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic [CNT_W:0]   ONE     = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] DMIN    = CNT_W'(DIV_MIN);

  baud_div_t div_a;     // divisor in force
  baud_div_t div_s;     // divisor waiting for the next tick
  baud_div_t div_in;
  baud_div_t div_nxt;
  logic      shadow_vld;
  logic      apply;
  logic      bad_nxt;
  logic      phase_clr;

  logic [CNT_W:0]  cnt;     // one spare bit so D = 2^CNT_W-1 plus carry cannot wrap
  logic [CNT_W:0]  p_last;
  logic [OS_W-1:0] os_cnt;
  logic            carry;
  logic            run;
  logic            tick;

  assign div_in = '{ipart: div_int, fpart: div_frac};
  assign run    = en & ~cfg_err;
  assign p_last = {1'b0, div_a.ipart} + {{CNT_W{1'b0}}, carry} - ONE;
  // >= rather than == so a smaller divisor loaded while held cannot strand cnt.
  assign tick   = run & ~restart & (cnt >= p_last);

  // Divisor selection: immediate when idle/stalled or on restart, otherwise
  // deferred to a tick so the running period never gets cut short.
  always_comb begin
    div_nxt = div_a;
    apply   = 1'b0;
    if (restart || !run) begin
      if (load) begin
        div_nxt = div_in;
        apply   = 1'b1;
      end else if (restart && shadow_vld) begin
        div_nxt = div_s;
        apply   = 1'b1;
      end
    end else if (tick) begin
      if (load) begin
        div_nxt = div_in;
        apply   = 1'b1;
      end else if (shadow_vld) begin
        div_nxt = div_s;
        apply   = 1'b1;
      end
    end
  end

  assign bad_nxt   = (div_nxt.ipart < DMIN);
  // An invalid divisor parks the phase at zero so a later valid load starts clean.
  assign phase_clr = restart | (apply & bad_nxt);

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      div_a      <= '{ipart: CNT_W_DEF'(DIV_RST), fpart: '0};
      div_s      <= '0;
      shadow_vld <= 1'b0;
      cfg_err    <= (DIV_RST < DIV_MIN);
    end else begin
      div_a   <= div_nxt;
      cfg_err <= bad_nxt;
      if (apply) begin
        shadow_vld <= 1'b0;
      end else if (load) begin
        div_s      <= div_in;
        shadow_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      os_cnt <= '0;
    end else if (phase_clr) begin
      cnt    <= '0;
      os_cnt <= '0;
    end else if (tick) begin
      cnt    <= '0;
      os_cnt <= os_cnt + 1'b1;
    end else if (run) begin
      cnt    <= cnt + ONE;
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= tick;
      mid_tick <= tick & (os_cnt == OS_MID);
      bit_tick <= tick & (os_cnt == OS_LAST);
    end
  end

`ifdef BAUD_FRAC_EN
  frac_accum #(
    .FRAC_W(FRAC_W)
  ) u_frac_accum (
    .in_clk(in_clk),
    .rst   (rst),
    .step  (tick),
    .clr   (phase_clr),
    .frac  (div_a.fpart),
    .carry (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^div_a.fpart;
  assign carry       = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: interval measurements against hand-computed values.
// Latency: n/a.
// Backpressure: n/a.
module tb_baud_tick_gen;

  logic        in_clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        load;
  logic        restart;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic        cfg_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 in_clk = ~in_clk;

  baud_tick_gen dut (
    .in_clk  (in_clk),
    .rst     (rst),
    .en      (en),
    .div_int (div_int),
    .div_frac(div_frac),
    .load    (load),
    .restart (restart),
    .os_tick (os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .cfg_err (cfg_err)
  );

  task automatic check(input string tag, input int obs, input int want);
    n_chk++;
    if (obs == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, want);
  endtask

  function automatic logic strobe(input int sel);
    case (sel)
      0:       return os_tick;
      1:       return mid_tick;
      default: return bit_tick;
    endcase
  endfunction

  // Clocks from the current negedge until the selected strobe is seen; -1 on timeout.
  task automatic measure(input int sel, input int limit, output int k);
    int  n   = 0;
    logic hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge in_clk);
      n++;
      hit = strobe(sel);
    end
    k = hit ? n : -1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge in_clk);
  endtask

  task automatic do_load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    load     = 1'b1;
    @(negedge in_clk);
    load     = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge in_clk);
    restart = 1'b0;
  endtask

  initial begin
    int k;
    int hits;

    rst      = 1'b0;
    en       = 1'b1;
    div_int  = 16'd27;
    div_frac = 4'd0;
    load     = 1'b0;
    restart  = 1'b0;

    // Reset state
    steps(3);
    check("rst_os",  int'(os_tick),  0);
    check("rst_mid", int'(mid_tick), 0);
    check("rst_bit", int'(bit_tick), 0);
    check("rst_err", int'(cfg_err),  0);

    // Default divisor 27, OSR 16
    rst = 1'b1;
    measure(0, 100, k);  check("first_os", k, 27);
    measure(0, 100, k);  check("os_int", k, 27);
    measure(2, 600, k);  check("first_bit", k, 432 - 54);
    measure(2, 600, k);  check("bit_int", k, 432);
    measure(1, 600, k);  check("mid_after_bit", k, 216);
    check("err_run", int'(cfg_err), 0);

    // Load while running: current period finishes at 27
    steps(5);
    do_load(10, 0);
    measure(0, 100, k);  check("load_cur", k, 21);
    measure(0, 100, k);  check("load_new1", k, 10);
    measure(0, 100, k);  check("load_new2", k, 10);

    // Two loads in one period: last one wins
    steps(2);
    do_load(4, 0);
    do_load(7, 0);
    measure(0, 100, k);  check("dbl_cur", k, 6);
    measure(0, 100, k);  check("dbl_new", k, 7);
    do_load(10, 0);
    measure(0, 100, k);  check("back_cur", k, 6);

    // Restart mid-bit at D=10
    steps(3);
    pulse_restart();
    measure(0, 100, k);  check("rs_os", k, 10);
    measure(1, 300, k);  check("rs_mid", k, 70);
    measure(2, 300, k);  check("rs_bit", k, 80);

    // Invalid divisor stalls, valid load recovers
    do_load(1, 0);
    measure(0, 100, k);  check("bad_cur", k, 9);
    check("err_set", int'(cfg_err), 1);
    measure(0, 40, k);   check("stall_no_os", k, -1);
    do_load(5, 0);
    check("err_clr", int'(cfg_err), 0);
    measure(0, 100, k);  check("rec_first", k, 5);
    measure(0, 100, k);  check("rec_int", k, 5);

    // en low holds mid-period, resumes without restart
    steps(2);
    en   = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge in_clk);
      if (os_tick) hits++;
    end
    check("en_hold", hits, 0);
    en = 1'b1;
    measure(0, 100, k);  check("en_resume", k, 3);

    // Async reset mid-strobe
    measure(0, 100, k);
    rst = 1'b0;
    #1;
    check("arst_os",  int'(os_tick), 0);
    check("arst_err", int'(cfg_err), 0);
    steps(3);
    rst = 1'b1;
    measure(0, 100, k);  check("post_rst_first", k, 27);
    measure(0, 100, k);  check("post_rst_int", k, 27);

`ifdef BAUD_FRAC_EN
    // Fractional divisor 27 + 2/16 with simultaneous restart and load
    begin
      int sum;
      div_int  = 16'd27;
      div_frac = 4'd2;
      load     = 1'b1;
      restart  = 1'b1;
      @(negedge in_clk);
      load     = 1'b0;
      restart  = 1'b0;
      measure(0, 100, k);  check("frac_first", k, 27);
      sum = 0;
      for (int i = 1; i <= 16; i++) begin
        measure(0, 100, k);
        check($sformatf("frac_int%0d", i), k, (i == 8 || i == 16) ? 28 : 27);
        sum += k;
      end
      check("frac_sum", sum, 434);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART: the next-generation replacement for the fixed integer clock divider. Produces single-cycle strobes for oversampling, bit boundaries and mid-bit sampling. Supports an optional fractional divisor, a runtime divisor reload that never produces a glitched period, and synchronous phase restart for RX start-bit alignment. Sits between the system clock and the UART TX/RX engines; strobes are clock enables, never clocks.

## Interface
- CNT_W, 16: width of integer divisor and period counter
- FRAC_W, 4: width of fractional divisor; fraction = div_frac / 2^FRAC_W
- OSR, 16: oversample ticks per bit; power of two, ≥ 4
- DIV_RST, 27: integer divisor after reset (fraction resets to 0)

- in_clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  run enable; low = all counters hold, no strobes
- div_int  input  CNT_W  integer clocks per oversample tick
- div_frac  input  FRAC_W  fractional clocks per oversample tick
- load  input  1  one-cycle request to take div_int/div_frac
- restart  input  1  one-cycle synchronous phase realign
- os_tick  output  1  oversample strobe
- mid_tick  output  1  mid-bit strobe
- bit_tick  output  1  bit-boundary strobe
- cfg_err  output  1  active integer divisor < 2; generator stalled

## Operation
- Reset (async, rst low): period counter, os_cnt, accumulator = 0; active divisor = {DIV_RST, 0}; shadow cleared; all strobes 0; cfg_err = (DIV_RST < 2).
- Period counter runs 0..P-1 while en=1 and cfg_err=0. P = div_int_a, or div_int_a+1 when the accumulator carried at the previous os_tick.
- Tick event when counter = P-1: counter → 0; accumulator += div_frac_a mod 2^FRAC_W; carry selects P for the next period; os_cnt increments mod OSR.
- bit_tick: coincident with the tick event whose os_cnt wraps OSR-1 → 0.
- mid_tick: coincident with the tick event moving os_cnt from OSR/2-1 to OSR/2.
- load with en=0 or cfg_err=1: applied to the active divisor at that edge.
- load while running: captured into shadow. Applied at the next tick event, so the current period completes with the old divisor. A second load before then overwrites the shadow.
- restart: counter, os_cnt and accumulator → 0. Any tick event that cycle is suppressed. A pending shadow is applied immediately.
- restart and load in the same cycle: new divisor active immediately, phase cleared.
- cfg_err is registered and tracks the active divisor. An invalid load is accepted, raises cfg_err and holds counters at 0. A later valid load clears cfg_err.
- en low: everything holds. Re-asserting en resumes mid-period, with no restart.

## Timing
- All strobes are registered and high for exactly one in_clk cycle, in the cycle after the tick event edge.
- First os_tick after reset release, restart, or valid load from stall: div_int clocks later.
- Steady state, integer divisor D: os_tick every D clocks; bit_tick every OSR·D; mid_tick (OSR/2)·D clocks after restart, then every OSR·D.
- Divisor change latency: ≤ one old period.
- Counter compare uses CNT_W+1 bits so that div_int = 2^CNT_W-1 with carry does not wrap.

## Configuration
- BAUD_FRAC_EN defined: accumulator present; period dithers between D and D+1.
- BAUD_FRAC_EN undefined: accumulator absent; div_frac port kept but ignored; P = div_int_a always.

## Structure
- Package baud_pkg holds:
  - DIV_MIN = 2
  - default OSR/CNT_W/FRAC_W constants
  - typedef baud_div_t {int, frac} for the active/shadow divisor registers
- One sub-module: frac_accum (accumulator + carry, with enable and clear), instantiated only under BAUD_FRAC_EN.

## Test plan
- Reset, en=1, defaults: os_tick every 27 clocks, bit_tick every 432 clocks, cfg_err=0, all outputs 0 during reset.
- BAUD_FRAC_EN, load {27, 2}: 16 consecutive os_tick intervals sum to 434, exactly two of length 28 (8th and 16th).
- restart mid-bit with D=10: no os_tick in the next 9 clocks; first os_tick at 10 clocks; mid_tick at 80 clocks; bit_tick at 160 clocks.
- load {10,0} while running at D=27: current interval stays 27, following intervals 10. Two loads in one period: only the last takes effect.
- load {1,0}: cfg_err=1, strobes stop. Then load {5,0}: cfg_err=0, first os_tick 5 clocks later.
- rst asserted mid-period: strobes drop asynchronously; after release, intervals are 27 with phase from 0.
